// File: rtl/lb_fifo_ctrl.sv
// Line-buffer FIFO controller: drives an external 2-port line memory and keeps
// the head line in a registered output slot with valid/ready handshakes.
module lb_fifo_ctrl #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 128,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 2)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic [AW-1:0]    W0_addr,
  output logic             W0_en,
  output logic [WIDTH-1:0] W0_data,
  output logic [AW-1:0]    R0_addr,
  output logic             R0_en,
  input  logic [WIDTH-1:0] R0_data
);

  logic [AW-1:0]    wptr, wptr_n;
  logic [AW-1:0]    rptr, rptr_n;
  logic [CW-1:0]    mem_cnt, mem_cnt_n;
  logic [CW-1:0]    count_n;
  logic             out_valid_n;
  logic [WIDTH-1:0] out_data_n;
  logic             wr, rd, full, empty;

  assign full  = (mem_cnt == CW'(DEPTH));
  assign empty = (mem_cnt == '0);

  // Handshake and memory strobes; all held off during reset and flush.
  assign in_ready = reset_n && !full && !flush;
  assign wr       = in_valid && in_ready;
  assign rd       = reset_n && !empty && !flush && (!out_valid || out_ready);

  assign W0_en   = wr;
  assign W0_addr = wptr;
  assign W0_data = in_data;
  assign R0_en   = rd;
  assign R0_addr = rptr;

  // Next-state: a read refills the output slot, otherwise a taken line empties it.
  always_comb begin
    wptr_n      = wptr;
    rptr_n      = rptr;
    mem_cnt_n   = mem_cnt;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    if (flush) begin
      wptr_n      = '0;
      rptr_n      = '0;
      mem_cnt_n   = '0;
      out_valid_n = 1'b0;
    end else begin
      if (wr) begin
        wptr_n = wptr + AW'(1);
      end
      if (rd) begin
        rptr_n      = rptr + AW'(1);
        out_valid_n = 1'b1;
        out_data_n  = R0_data;
      end else if (out_ready) begin
        out_valid_n = 1'b0;
      end
      if (wr && !rd) begin
        mem_cnt_n = mem_cnt + CW'(1);
      end else if (rd && !wr) begin
        mem_cnt_n = mem_cnt - CW'(1);
      end
    end
    count_n = mem_cnt_n + CW'(out_valid_n);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr      <= '0;
      rptr      <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      count     <= '0;
    end else begin
      wptr      <= wptr_n;
      rptr      <= rptr_n;
      mem_cnt   <= mem_cnt_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      count     <= count_n;
    end
  end

endmodule

// File: tb/tb_lb_fifo_ctrl.sv
// Bench for lb_fifo_ctrl: queue-based reference model checked every cycle,
// with directed scenarios and a long randomized valid/ready run.
module tb_lb_fifo_ctrl;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned WIDTH = 128;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [5:0]       count;
  logic [4:0]       W0_addr;
  logic             W0_en;
  logic [WIDTH-1:0] W0_data;
  logic [4:0]       R0_addr;
  logic             R0_en;
  logic [WIDTH-1:0] R0_data;

  lb_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data)
  );

  always #5 clock = ~clock;

  // External line memory; garbage is presented whenever the read port is idle.
  logic [WIDTH-1:0] tb_mem [DEPTH];
  logic [WIDTH-1:0] junk;
  always @(posedge clock) begin
    if (W0_en) tb_mem[W0_addr] <= W0_data;
    junk <= {$urandom, $urandom, $urandom, $urandom};
  end
  assign R0_data = R0_en ? tb_mem[R0_addr] : junk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: lines in the memory, plus the output slot.
  logic [WIDTH-1:0] mq[$];
  bit               ov;
  logic [WIDTH-1:0] od;
  int               wp, rp;
  bit               chk_en;
  bit               acc;
  int               pops;
  bit               m_ir, m_wr, m_rd;

  task automatic model_clear();
    mq.delete();
    ov = 0; od = '0; wp = 0; rp = 0; acc = 0;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      m_ir = (mq.size() != DEPTH) && !flush;
      m_wr = in_valid && m_ir;
      m_rd = (mq.size() != 0) && !flush && (!ov || out_ready);
      check("in_ready", 128'(in_ready), 128'(m_ir));
      check("out_valid", 128'(out_valid), 128'(ov));
      check("count", 128'(count), 128'(mq.size() + int'(ov)));
      check("count_bound", 128'(count <= 6'd33), 128'(1));
      check("W0_en", 128'(W0_en), 128'(m_wr));
      check("R0_en", 128'(R0_en), 128'(m_rd));
      if (ov) check("out_data", out_data, od);
      if (m_wr) begin
        check("W0_addr", 128'(W0_addr), 128'(wp));
        check("W0_data", W0_data, in_data);
      end
      if (m_rd) check("R0_addr", 128'(R0_addr), 128'(rp));
      if (ov && out_ready && !flush) pops++;
      acc = m_wr;
      if (flush) begin
        mq.delete(); ov = 0; wp = 0; rp = 0;
      end else begin
        if (m_rd) begin
          od = mq.pop_front(); ov = 1; rp = (rp + 1) % DEPTH;
        end else if (out_ready) begin
          ov = 0;
        end
        if (m_wr) begin
          mq.push_back(in_data); wp = (wp + 1) % DEPTH;
        end
      end
    end
  end

  int seq = 0;
  int n_acc = 0;

  function automatic logic [WIDTH-1:0] next_line();
    seq++;
    return {32'(seq), $urandom, $urandom, $urandom};
  endfunction

  // One clock of producer/consumer activity; producer data advances only on accept.
  task automatic drive_cycle(input bit v, input bit r);
    in_valid  = v;
    out_ready = r;
    @(posedge clock);
    #1;
    if (acc) begin
      n_acc++;
      in_data = next_line();
    end
  endtask

  int n0, p0;

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_data = {16{8'hA5}}; chk_en = 0; pops = 0;
    model_clear();
    #2;
    check("rst_count", 128'(count), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    check("rst_W0_en", 128'(W0_en), 128'(0));
    check("rst_R0_en", 128'(R0_en), 128'(0));
    @(posedge clock); @(posedge clock); #3;
    reset_n = 1'b1; in_valid = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    chk_en = 1;

    // Single line latency through an empty FIFO.
    drive_cycle(1, 1);
    check("lat_e0_count", 128'(count), 128'(1));
    check("lat_e0_out_valid", 128'(out_valid), 128'(0));
    drive_cycle(0, 1);
    check("lat_e1_out_valid", 128'(out_valid), 128'(1));
    check("lat_e1_out_data", out_data, {16{8'hA5}});
    check("lat_e1_count", 128'(count), 128'(1));
    drive_cycle(0, 1);
    check("lat_e2_count", 128'(count), 128'(0));
    check("lat_e2_out_valid", 128'(out_valid), 128'(0));

    // Fill to capacity with the consumer stalled.
    n0 = n_acc;
    repeat (34) drive_cycle(1, 0);
    check("full_accepted", 128'(n_acc - n0), 128'(33));
    check("full_count", 128'(count), 128'(33));
    check("full_in_ready", 128'(in_ready), 128'(0));
    drive_cycle(1, 1);
    drive_cycle(1, 0);
    check("full_34th_accepted", 128'(n_acc - n0), 128'(34));
    check("full_count_again", 128'(count), 128'(33));
    repeat (40) drive_cycle(0, 1);
    check("drain_count", 128'(count), 128'(0));

    // Streaming: one line per cycle across several pointer wraps.
    n0 = n_acc; p0 = pops;
    repeat (50) drive_cycle(1, 1);
    check("stream_steady_count", 128'(count), 128'(2));
    repeat (50) drive_cycle(1, 1);
    repeat (3) drive_cycle(0, 1);
    check("stream_accepted", 128'(n_acc - n0), 128'(100));
    check("stream_popped", 128'(pops - p0), 128'(100));

    // Flush with ten lines held.
    repeat (10) drive_cycle(1, 0);
    check("flush_pre_count", 128'(count), 128'(10));
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("flush_W0_en", 128'(W0_en), 128'(0));
    check("flush_R0_en", 128'(R0_en), 128'(0));
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_count", 128'(count), 128'(0));
    check("flush_out_valid", 128'(out_valid), 128'(0));
    repeat (4) drive_cycle(1, 1);
    repeat (4) drive_cycle(0, 1);

    // Asynchronous reset in the middle of a burst.
    repeat (7) drive_cycle(1, 0);
    check("rmid_pre_count", 128'(count), 128'(7));
    #2;
    chk_en = 0;
    reset_n = 1'b0;
    #1;
    check("rmid_count", 128'(count), 128'(0));
    check("rmid_out_valid", 128'(out_valid), 128'(0));
    check("rmid_out_data", out_data, 128'(0));
    check("rmid_W0_en", 128'(W0_en), 128'(0));
    check("rmid_R0_en", 128'(R0_en), 128'(0));
    model_clear();
    @(posedge clock); @(posedge clock); #3;
    reset_n = 1'b1;
    in_data = next_line();
    chk_en = 1;
    repeat (20) drive_cycle(1, 1'($urandom_range(0, 1)));
    repeat (40) drive_cycle(0, 1);
    check("rmid_drained", 128'(count), 128'(0));

    // Random valid/ready traffic with occasional flushes.
    repeat (10000) begin
      flush = ($urandom_range(0, 63) == 0);
      drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    flush = 1'b0;
    repeat (40) drive_cycle(0, 1);
    check("final_count", 128'(count), 128'(0));

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
